// File: rtl/router_pkg.sv
// Shared definitions for the router ejection path: header field layout and
// the eject FSM state encoding.
package router_pkg;

  localparam int RST_CMD_BIT = 63;
  localparam int LEN_LSB     = 0;
  localparam int LEN_W       = 16;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    PRST = 2'd2
  } eject_state_e;

endpackage

// File: rtl/router_sync_fifo.sv
// Single-clock FIFO with combinational head read. Push while full is dropped
// unless a pop happens in the same cycle.
module router_sync_fifo #(
  parameter int Width = 65,
  parameter int Depth = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_count
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr, w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(Depth));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_rd = i_pop & ~o_empty;
  assign w_wr = i_push & (~o_full | w_rd);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  // storage is not reset; PE_D is gated by PE_VALID at the top level
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/router_pe_eject.sv
// Router-to-PE ejection: buffers router words, strips frame headers, hands
// payload to the PE over valid/ready and turns reset headers into PE_RST.
module router_pe_eject
  import router_pkg::*;
#(
  parameter int Depth     = 8,
  parameter int RstCycles = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] D,
  input  logic        D_VALID,
  input  logic        D_SOF,
  output logic        D_BP,
  output logic [63:0] PE_D,
  output logic        PE_VALID,
  input  logic        PE_READY,
  output logic        PE_LAST,
  output logic        PE_RST,
  output logic        PE_ERR
);

  localparam int CW = $clog2(Depth) + 1;

  logic [64:0]      w_head;
  logic             w_full, w_empty, w_pop, w_push_ok;
  logic [CW-1:0]    w_count, w_cnt_nxt;
  logic             w_head_sof, w_hdr_rst;
  logic [LEN_W-1:0] w_hdr_len;

  eject_state_e     r_state, w_state_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic [7:0]       r_rcnt, w_rcnt_nxt;
  logic             r_bp, r_pe_rst;
  logic             w_valid, w_last, w_err;

  router_sync_fifo #(.Width(65), .Depth(Depth)) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (D_VALID),
    .i_wdata ({D_SOF, D}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_head_sof = w_head[64];
  assign w_hdr_rst  = w_head[RST_CMD_BIT];
  assign w_hdr_len  = w_head[LEN_LSB +: LEN_W];

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_rcnt_nxt  = r_rcnt;
    w_pop       = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      HDR: if (!w_empty) begin
        // headers are consumed internally; stray payload words just fall out
        w_pop = 1'b1;
        if (w_head_sof) begin
          if (w_hdr_rst) begin
            w_rcnt_nxt  = 8'(RstCycles);
            w_state_nxt = PRST;
          end else if (w_hdr_len != '0) begin
            w_rem_nxt   = w_hdr_len;
            w_state_nxt = DATA;
          end
        end
      end
      DATA: if (!w_empty) begin
        if (w_head_sof) begin
          // truncated frame: leave the new header for HDR to decode
          w_err       = 1'b1;
          w_state_nxt = HDR;
        end else begin
          w_valid = 1'b1;
          w_last  = (r_rem == LEN_W'(1));
          if (PE_READY) begin
            w_pop     = 1'b1;
            w_rem_nxt = r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) w_state_nxt = HDR;
          end
        end
      end
      PRST: begin
        w_rcnt_nxt = r_rcnt - 8'd1;
        if (r_rcnt == 8'd1) w_state_nxt = HDR;
      end
      default: w_state_nxt = HDR;
    endcase
  end

  assign w_push_ok = D_VALID & (~w_full | w_pop);
  assign w_cnt_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= HDR;
      r_rem    <= '0;
      r_rcnt   <= '0;
      r_bp     <= 1'b0;
      r_pe_rst <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      r_rcnt   <= w_rcnt_nxt;
      r_bp     <= (w_cnt_nxt >= CW'(Depth - 2));
      r_pe_rst <= (w_state_nxt == PRST);
    end
  end

  assign D_BP     = r_bp;
  assign PE_RST   = r_pe_rst;
  assign PE_VALID = w_valid;
  assign PE_LAST  = w_last;
  assign PE_ERR   = w_err;
  assign PE_D     = w_valid ? w_head[63:0] : '0;

endmodule

// File: doc/router_pe_eject.md
# router_pe_eject

Ejection stage between one router output port (Q/Q_VALID/Q_SOF/Q_BP) and the local processing element. It absorbs router words in a small FIFO with a registered backpressure return and decodes frames: a 64-bit header word (marked by Q_SOF) followed by a payload count. It strips the header, delivers payload words to the PE over valid/ready with a last flag, and turns reset-command headers into a timed PE_RST pulse.

## Interface
- Depth, 8: FIFO entries (power of two, ≥4)
- RstCycles, 16: PE_RST pulse length in cycles (1..255)
- CLK  in  1  clock, all logic rising-edge
- RST  in  1  reset; asynchronous, active-low
- D  in  64  router output word (router Q)
- D_VALID  in  1  word valid (router Q_VALID)
- D_SOF  in  1  word is a frame header (router Q_SOF)
- D_BP  out  1  backpressure to router (router Q_BP), registered
- PE_D  out  64  payload word
- PE_VALID  out  1  payload valid
- PE_READY  in  1  PE accepts payload
- PE_LAST  out  1  final payload word of frame
- PE_RST  out  1  reset to PE, active-high, registered
- PE_ERR  out  1  one-cycle pulse: truncated frame detected

## Operation
- Header: bit 63 = reset command, bits 15:0 = payload length N (0..65535); other bits ignored.
- Write: any cycle with D_VALID=1 pushes {D_SOF,D}. Push while full is a protocol violation: word dropped, no other state change.
- D_BP registered: next value = 1 iff occupancy after this cycle's push/pop ≥ Depth−2. Router may still deliver up to 2 words after D_BP rises.
- FSM (state encoding in package):
  - HDR: pop head without PE handshake. If head SOF=0: discard (stray payload). If SOF=1 and bit63=1: load rst counter=RstCycles, go PRST. Else if N=0: stay HDR. Else load remaining=N, go DATA.
  - DATA: PE_VALID=1 when FIFO non-empty and head SOF=0; PE_D=head data; PE_LAST=(remaining==1). Pop on PE_VALID&PE_READY, decrement; at remaining 1→0 go HDR. Head SOF=1 in DATA: PE_VALID=0, PE_ERR pulse, go HDR without popping (head re-decoded as header next cycle).
  - PRST: PE_RST=1; counter decrements each cycle; on reaching 1 go HDR (PE_RST low the following cycle). FIFO keeps filling; no pops in PRST.
- PE_VALID, once asserted, holds with stable PE_D/PE_LAST until accepted (cannot be withdrawn except by SOF-detected head, which never appears under a valid word).

## Timing
- Reset values: D_BP=0, PE_VALID=0, PE_LAST=0, PE_RST=0, PE_ERR=0, PE_D=0, FIFO empty, state HDR, counters 0.
- Latency: word on D at cycle t becomes head at t+1; header decoded at t+1, first payload offered t+2 at earliest; PE_VALID combinational from FIFO head/state.
- Throughput: one payload word per cycle at full rate; header costs one cycle.
- Simultaneous push and pop: occupancy unchanged, legal when full.
- PE_RST asserted first cycle after header pop, held exactly RstCycles cycles.
- PE_ERR asserted in the same cycle the SOF head is seen in DATA.
- RST assertion mid-frame or mid-PRST: all outputs to reset values immediately (async), FIFO flushed.
- remaining counter 16 bits; N=65535 must not wrap.

## Structure
- router_pkg: header field constants (RST_CMD_BIT=63, LEN_LSB=0, LEN_W=16), eject FSM state enum {HDR,DATA,PRST}.
- Sub-module router_sync_fifo (parameter Width, Depth; push/pop/full/empty/count), width 65.
- Top holds FSM, counters, D_BP register, output decode.

## Test plan
- Header N=3 then 3 words, PE_READY=1 → PE sees 3 words, PE_LAST only on third, first PE_VALID 2 cycles after header.
- Header with bit63=1, RstCycles=16 → PE_RST high exactly 16 cycles, next frame N=1 delivered afterwards.
- PE_READY=0, continuous D_VALID, Depth=8 → D_BP high once occupancy reaches 6; with router stopping 2 cycles later, no word lost; release READY → all words delivered in order.
- Header N=4, 2 words, then new SOF header N=1 + word → PE_ERR one cycle, 2 words without PE_LAST, then 1 word with PE_LAST.
- Header N=0 followed immediately by header N=1 → nothing for first, one word with PE_LAST for second.
- Assert RST mid-payload → outputs zero asynchronously; after release, fresh frame N=2 delivered normally.
